// File: rtl/sort_pkg.sv
// Shared types for the nibble packer and the 4x4-bit sorter.
// One word is four nibble lanes; lane 0 sits in the top bits.
package sort_pkg;
  localparam int NIBBLE_W = 4;
  localparam int LANES    = 4;

  typedef logic [NIBBLE_W-1:0]       nibble_t;
  typedef logic [LANES*NIBBLE_W-1:0] word_t;
endpackage

// File: rtl/nibble_packer.sv
// Packs four streamed nibbles into one 16-bit word for the sorter.
// Double-buffered: assembly continues while a finished word waits.
module nibble_packer
  import sort_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  nibble_t          in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output word_t            out_data,
  output logic [2:0]       fill,
  output logic [CNT_W-1:0] word_cnt
);

  logic [1:0]       cnt_q, cnt_d;
  word_t            asm_q, asm_d;
  logic             full_q, full_d;
  word_t            odat_q, odat_d;
  logic             oval_q, oval_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;

  logic  acc, out_free, out_hs;
  word_t asm_ins;

  assign in_ready = !full_q;
  assign acc      = in_valid && !full_q;
  assign out_free = !oval_q || out_ready;
  assign out_hs   = oval_q && out_ready;

  // Assembly word with the incoming nibble dropped into slot cnt.
  always_comb begin
    asm_ins = asm_q;
    unique case (cnt_q)
      2'd0: asm_ins[15:12] = in_data;
      2'd1: asm_ins[11:8]  = in_data;
      2'd2: asm_ins[7:4]   = in_data;
      2'd3: asm_ins[3:0]   = in_data;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    asm_d  = asm_q;
    full_d = full_q;
    odat_d = odat_q;
    oval_d = oval_q && !out_hs;
    wcnt_d = out_hs ? wcnt_q + 1'b1 : wcnt_q;
    if (clear) begin
      cnt_d  = '0;
      full_d = 1'b0;
    end else if (full_q) begin
      if (out_free) begin
        odat_d = asm_q;
        oval_d = 1'b1;
        full_d = 1'b0;
        cnt_d  = '0;
      end
    end else if (acc) begin
      asm_d = asm_ins;
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        if (out_free) begin
          odat_d = asm_ins;
          oval_d = 1'b1;
        end else begin
          full_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q  <= '0;
      asm_q  <= '0;
      full_q <= 1'b0;
      odat_q <= '0;
      oval_q <= 1'b0;
      wcnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      asm_q  <= asm_d;
      full_q <= full_d;
      odat_q <= odat_d;
      oval_q <= oval_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign out_data  = odat_q;
  assign out_valid = oval_q;
  assign word_cnt  = wcnt_q;
  assign fill      = full_q ? 3'd4 : {1'b0, cnt_q};

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer: a default-width instance and a
// CNT_W=2 instance share all inputs.
module tb_nibble_packer;
  import sort_pkg::*;

  logic       clk = 1'b0;
  logic       nrst, clear, in_valid, out_ready;
  nibble_t    in_data;
  logic       in_ready, out_valid, in_ready2, out_valid2;
  word_t      out_data, out_data2;
  logic [2:0] fill, fill2;
  logic [7:0] word_cnt;
  logic [1:0] word_cnt2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  nibble_packer dut (
    .clk(clk), .nrst(nrst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fill(fill), .word_cnt(word_cnt)
  );

  nibble_packer #(.CNT_W(2)) dut2 (
    .clk(clk), .nrst(nrst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .fill(fill2), .word_cnt(word_cnt2)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
  endtask

  initial begin
    logic [15:0] w;
    nrst = 1'b0; clear = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_data = 4'h0;
    #12;
    chk("rst_oval", 16'(out_valid), 16'd0);
    chk("rst_odat", out_data, 16'h0000);
    chk("rst_wcnt", 16'(word_cnt), 16'd0);
    chk("rst_fill", 16'(fill), 16'd0);
    chk("rst_irdy", 16'(in_ready), 16'd1);
    nrst = 1'b1;
    step();

    // single word
    out_ready = 1'b1;
    feed(4'h4); chk("sw_fill1", 16'(fill), 16'd1);
    feed(4'h7); chk("sw_fill2", 16'(fill), 16'd2);
    feed(4'h1); chk("sw_fill3", 16'(fill), 16'd3);
    chk("sw_nov", 16'(out_valid), 16'd0);
    feed(4'hC);
    chk("sw_fill0", 16'(fill), 16'd0);
    chk("sw_oval", 16'(out_valid), 16'd1);
    chk("sw_odat", out_data, 16'h471C);
    chk("sw_wc0", 16'(word_cnt), 16'd0);
    in_valid = 1'b0;
    step();
    chk("sw_oval_drop", 16'(out_valid), 16'd0);
    chk("sw_wc1", 16'(word_cnt), 16'd1);
    chk("sw_hold", out_data, 16'h471C);

    // backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      feed(4'(i));
      if (i == 3) chk("bp_first", out_data, 16'h0123);
    end
    chk("bp_fill4", 16'(fill), 16'd4);
    chk("bp_irdy0", 16'(in_ready), 16'd0);
    chk("bp_stable", out_data, 16'h0123);
    in_valid = 1'b0;
    step();
    chk("bp_stable2", out_data, 16'h0123);
    chk("bp_irdy0b", 16'(in_ready), 16'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_second", out_data, 16'h4567);
    chk("bp_oval", 16'(out_valid), 16'd1);
    chk("bp_irdy1", 16'(in_ready), 16'd1);
    chk("bp_fill0", 16'(fill), 16'd0);
    chk("bp_wc2", 16'(word_cnt), 16'd2);
    out_ready = 1'b1;
    step();
    chk("bp_drain", 16'(out_valid), 16'd0);
    chk("bp_wc3", 16'(word_cnt), 16'd3);

    // clear
    feed(4'h9); feed(4'h9);
    chk("cl_fill2", 16'(fill), 16'd2);
    clear = 1'b1;
    feed(4'h5);
    clear = 1'b0;
    chk("cl_fill0", 16'(fill), 16'd0);
    feed(4'hA); feed(4'hB); feed(4'hC); feed(4'hD);
    chk("cl_odat", out_data, 16'hABCD);
    chk("cl_oval", 16'(out_valid), 16'd1);
    in_valid = 1'b0;
    step();
    chk("cl_wc4", 16'(word_cnt), 16'd4);
    chk("cl_wc4_n", 16'(word_cnt2), 16'd0);

    // clear while a word waits
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) feed(4'h1);
    for (int i = 0; i < 4; i++) feed(4'h2);
    chk("cw_fill4", 16'(fill), 16'd4);
    in_valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("cw_fill0", 16'(fill), 16'd0);
    chk("cw_irdy", 16'(in_ready), 16'd1);
    chk("cw_odat", out_data, 16'h1111);
    out_ready = 1'b1;
    step();
    chk("cw_wc5", 16'(word_cnt), 16'd5);
    chk("cw_oval0", 16'(out_valid), 16'd0);
    step();
    chk("cw_noxfer", 16'(out_valid), 16'd0);
    chk("cw_wc5b", 16'(word_cnt), 16'd5);
    chk("cw_odat2", out_data, 16'h1111);

    // reset mid-word
    feed(4'h6); feed(4'h6);
    in_valid = 1'b0;
    nrst = 1'b0;
    #1;
    chk("rm_fill", 16'(fill), 16'd0);
    chk("rm_odat", out_data, 16'h0000);
    chk("rm_wcnt", 16'(word_cnt), 16'd0);
    chk("rm_irdy", 16'(in_ready), 16'd1);
    chk("rm_oval", 16'(out_valid), 16'd0);
    #2 nrst = 1'b1;
    feed(4'hE); feed(4'hD); feed(4'hC); feed(4'hB);
    chk("rm_edcb", out_data, 16'hEDCB);
    chk("rm_oval1", 16'(out_valid), 16'd1);

    // throughput and counter wrap, from a fresh reset
    in_valid = 1'b0;
    nrst = 1'b0;
    #2 nrst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("tp_irdy", 16'(in_ready), 16'd1);
      feed(4'(i));
      if (i % 4 == 3) begin
        w = {4'(i - 3), 4'(i - 2), 4'(i - 1), 4'(i)};
        chk("tp_word", out_data, w);
        chk("tp_oval", 16'(out_valid), 16'd1);
      end
    end
    in_valid = 1'b0;
    step();
    chk("wr_wc8", 16'(word_cnt), 16'd5);
    chk("wr_wc2", 16'(word_cnt2), 16'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
